episode_scheduler: RTL and testbench
====================================

EPISODE_SCHEDULER -- requirements
Module: episode_scheduler

Interface
REQ-001 SHALL take parameter NUM_EPISODES, default 1000, number of training episodes per run (>=1).
REQ-002 SHALL take parameter MAX_STEPS, default 64, step cap per episode (>=1).
REQ-003 SHALL take parameter EP_W, default 16, episode counter width (2^EP_W > NUM_EPISODES).
REQ-004 SHALL take parameter STEP_W, default 8, step counter width (2^STEP_W > MAX_STEPS).
REQ-005 SHALL take parameters EPS_W 16, EPS_INIT 16'hFFFF, EPS_DECAY 16'd64, EPS_MIN 16'd1638: exploration-rate width, start value, per-episode decrement, floor.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports i_start, input, 1, run start pulse, and i_abort, input, 1, run cancel.
REQ-009 SHALL have ports i_step_valid, input, 1, step-complete strobe from the Q-update pipeline, and i_terminal, input, 1, goal/terminal flag, sampled only with i_step_valid.
REQ-010 SHALL have ports i_write_done, input, 1, Q-table dump finished.
REQ-011 SHALL have outputs o_step_valid 1 (issue-step pulse), o_episode EP_W, o_step STEP_W, o_epsilon EPS_W, o_last_len STEP_W+1 (length of last finished episode).
REQ-012 SHALL have outputs o_write_req 1, o_busy 1, o_done 1.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-014 IDLE/DONE + i_start: o_episode=0, o_step=0, o_epsilon=EPS_INIT, o_done=0, next ISSUE.
REQ-015 ISSUE: o_step_valid high exactly one cycle, then WAIT.
REQ-016 WAIT without i_step_valid: hold all counters, o_step_valid low.
REQ-017 WAIT + i_step_valid, i_terminal=0, o_step<MAX_STEPS-1: o_step+1, next ISSUE.
REQ-018 WAIT + i_step_valid with i_terminal=1 or o_step==MAX_STEPS-1: episode end; o_last_len=o_step+1, o_step=0, o_epsilon=max(o_epsilon-EPS_DECAY, EPS_MIN) without unsigned underflow.
REQ-019 At episode end, o_episode<NUM_EPISODES-1: o_episode+1, next ISSUE; o_episode==NUM_EPISODES-1: o_episode held, next WRITE.
REQ-020 WRITE: o_write_req held high until i_write_done, then DONE; i_write_done outside WRITE ignored.
REQ-021 DONE: o_done high, all counters held, until i_start.
REQ-022 i_abort in any state except IDLE: next IDLE, o_write_req/o_step_valid/o_done low, counters held for inspection.
REQ-023 i_abort and i_start same cycle: abort wins; i_start in ISSUE/WAIT/WRITE ignored.
REQ-024 i_step_valid in IDLE/ISSUE/WRITE/DONE ignored.
REQ-025 o_busy high in ISSUE, WAIT, WRITE; low in IDLE, DONE.
REQ-026 All outputs registered; step-to-next-issue latency 2 cycles (WAIT->ISSUE->pulse).

Reset
REQ-027 rst asserted: state IDLE, o_episode=0, o_step=0, o_last_len=0, o_epsilon=EPS_INIT, all 1-bit outputs 0, applied immediately regardless of clk.
REQ-028 Reset mid-run abandons the run; no o_write_req after deassertion until a new run completes.

Structure
REQ-029 FSM state enumeration, EPS_* defaults and counter widths SHALL live in the shared parameter package with existing COUNTER_WIDTH/NUMBER_OF_LOOP constants.
REQ-030 Epsilon saturating decay SHALL be one sub-module, eps_decay_sat (combinational subtract-and-clamp); remaining logic in one module.

Verification
REQ-031 NUM_EPISODES=3, MAX_STEPS=4, i_step_valid 1 cycle after each o_step_valid, i_terminal=0 -> 12 o_step_valid pulses, o_last_len=4, o_write_req rises after 12th strobe.
REQ-032 Episode 0 i_terminal=1 at o_step=1 -> o_last_len=2, o_episode=1, o_step=0 next cycle.
REQ-033 EPS_INIT=100, EPS_DECAY=40, EPS_MIN=30, 4 episodes -> o_epsilon 100,60,30,30.
REQ-034 i_abort during WAIT at o_episode=1, o_step=2 -> IDLE, o_busy=0, counters 1/2; i_start then restarts at 0/0.
REQ-035 rst pulse mid-WRITE -> o_write_req low asynchronously; i_write_done afterwards produces no o_done.
REQ-036 WRITE with i_write_done delayed 10 cycles -> o_write_req high 10 cycles, o_done the cycle after i_write_done.

Source files
------------

// File: rtl/episode_scheduler_pkg.sv
// Shared parameters and state encoding for the episode scheduler.
// Holds the legacy loop constants alongside the scheduler defaults.
package episode_scheduler_pkg;

  localparam int COUNTER_WIDTH  = 16;
  localparam int NUMBER_OF_LOOP = 1000;

  localparam int EP_W_DEF      = COUNTER_WIDTH;
  localparam int STEP_W_DEF    = 8;
  localparam int MAX_STEPS_DEF = 64;
  localparam int EPS_W_DEF     = 16;

  localparam logic [15:0] EPS_INIT_DEF  = 16'hFFFF;
  localparam logic [15:0] EPS_DECAY_DEF = 16'd64;
  localparam logic [15:0] EPS_MIN_DEF   = 16'd1638;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_ISSUE) || (s == S_WAIT) || (s == S_WRITE);
  endfunction

endpackage

// File: rtl/episode_scheduler_if.sv
// Control/status bundle between the scheduler and the training pipeline.
// The slave modport is the scheduler's view; master is the pipeline's view.
interface episode_scheduler_if
  import episode_scheduler_pkg::*;
#(
  parameter int EP_W   = EP_W_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int EPS_W  = EPS_W_DEF
);

  logic              i_start;
  logic              i_abort;
  logic              i_step_valid;
  logic              i_terminal;
  logic              i_write_done;

  logic              o_step_valid;
  logic [EP_W-1:0]   o_episode;
  logic [STEP_W-1:0] o_step;
  logic [EPS_W-1:0]  o_epsilon;
  logic [STEP_W:0]   o_last_len;
  logic              o_write_req;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_start, i_abort, i_step_valid, i_terminal, i_write_done,
    output o_step_valid, o_episode, o_step, o_epsilon, o_last_len,
           o_write_req, o_busy, o_done
  );

  modport master (
    output i_start, i_abort, i_step_valid, i_terminal, i_write_done,
    input  o_step_valid, o_episode, o_step, o_epsilon, o_last_len,
           o_write_req, o_busy, o_done
  );

endinterface

// File: rtl/episode_scheduler_eps_decay_sat.sv
// Exploration-rate decay: subtract a fixed step and clamp at a floor.
// The compare before subtraction keeps an unsigned wrap from escaping the clamp.
module eps_decay_sat #(
  parameter int               EPS_W     = 16,
  parameter logic [EPS_W-1:0] EPS_DECAY = '0,
  parameter logic [EPS_W-1:0] EPS_MIN   = '0
) (
  input  logic [EPS_W-1:0] i_eps,
  output logic [EPS_W-1:0] o_eps
);

  logic [EPS_W-1:0] w_diff;
  logic             w_underflow;

  assign w_diff      = i_eps - EPS_DECAY;
  assign w_underflow = (i_eps < EPS_DECAY);
  assign o_eps       = (w_underflow || (w_diff < EPS_MIN)) ? EPS_MIN : w_diff;

endmodule

// File: rtl/episode_scheduler.sv
// Training-run sequencer: issues steps, tracks episodes, decays epsilon and
// requests a Q-table dump when the last episode ends.
module episode_scheduler
  import episode_scheduler_pkg::*;
#(
  parameter int               NUM_EPISODES = NUMBER_OF_LOOP,
  parameter int               MAX_STEPS    = MAX_STEPS_DEF,
  parameter int               EP_W         = EP_W_DEF,
  parameter int               STEP_W       = STEP_W_DEF,
  parameter int               EPS_W        = EPS_W_DEF,
  parameter logic [EPS_W-1:0] EPS_INIT     = EPS_W'(EPS_INIT_DEF),
  parameter logic [EPS_W-1:0] EPS_DECAY    = EPS_W'(EPS_DECAY_DEF),
  parameter logic [EPS_W-1:0] EPS_MIN      = EPS_W'(EPS_MIN_DEF)
) (
  input logic                clk,
  input logic                rst,
  episode_scheduler_if.slave bus
);

  state_t            r_state, w_state_nxt;
  logic [EP_W-1:0]   r_episode, w_episode_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [EPS_W-1:0]  r_epsilon, w_epsilon_nxt;
  logic [STEP_W:0]   r_last_len, w_last_len_nxt;
  logic              r_step_valid, r_write_req, r_busy, r_done;
  logic [EPS_W-1:0]  w_eps_decayed;
  logic              w_step_last, w_ep_last;

  eps_decay_sat #(
    .EPS_W    (EPS_W),
    .EPS_DECAY(EPS_DECAY),
    .EPS_MIN  (EPS_MIN)
  ) u_eps_decay (
    .i_eps(r_epsilon),
    .o_eps(w_eps_decayed)
  );

  assign w_step_last = (r_step == STEP_W'(MAX_STEPS - 1));
  assign w_ep_last   = (r_episode == EP_W'(NUM_EPISODES - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_episode_nxt  = r_episode;
    w_step_nxt     = r_step;
    w_epsilon_nxt  = r_epsilon;
    w_last_len_nxt = r_last_len;

    if (bus.i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            w_state_nxt   = S_ISSUE;
            w_episode_nxt = '0;
            w_step_nxt    = '0;
            w_epsilon_nxt = EPS_INIT;
          end
        end
        S_ISSUE: w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (bus.i_step_valid) begin
            if (bus.i_terminal || w_step_last) begin
              w_last_len_nxt = (STEP_W + 1)'(r_step) + (STEP_W + 1)'(1);
              w_step_nxt     = '0;
              w_epsilon_nxt  = w_eps_decayed;
              if (w_ep_last) begin
                w_state_nxt = S_WRITE;
              end else begin
                w_episode_nxt = r_episode + EP_W'(1);
                w_state_nxt   = S_ISSUE;
              end
            end else begin
              w_step_nxt  = r_step + STEP_W'(1);
              w_state_nxt = S_ISSUE;
            end
          end
        end
        S_WRITE: begin
          if (bus.i_write_done) w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Flags are decoded from the next state so they are registered yet line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_episode    <= '0;
      r_step       <= '0;
      r_epsilon    <= EPS_INIT;
      r_last_len   <= '0;
      r_step_valid <= 1'b0;
      r_write_req  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state      <= w_state_nxt;
      r_episode    <= w_episode_nxt;
      r_step       <= w_step_nxt;
      r_epsilon    <= w_epsilon_nxt;
      r_last_len   <= w_last_len_nxt;
      r_step_valid <= (w_state_nxt == S_ISSUE);
      r_write_req  <= (w_state_nxt == S_WRITE);
      r_busy       <= is_busy(w_state_nxt);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.o_step_valid = r_step_valid;
  assign bus.o_episode    = r_episode;
  assign bus.o_step       = r_step;
  assign bus.o_epsilon    = r_epsilon;
  assign bus.o_last_len   = r_last_len;
  assign bus.o_write_req  = r_write_req;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;

endmodule

// File: tb/tb_episode_scheduler.sv
// Self-checking bench for episode_scheduler: a scoreboarded full run, a
// table-driven terminal/step-cap run, and abort/reset/write-handshake sequences.
module tb_episode_scheduler;

  localparam int NUM_EP = 3;
  localparam int MAX_ST = 4;
  localparam int EPW    = 16;
  localparam int STW    = 8;
  localparam int EPSW   = 16;
  localparam int E_INIT = 100;
  localparam int E_DEC  = 40;
  localparam int E_MIN  = 30;

  typedef struct {
    int ep;
    int step;
    int eps;
  } issue_t;

  typedef struct {
    logic term;
    int   ep;
    int   step;
    int   last_len;
    int   eps;
    logic sv;
    logic wreq;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulse_cnt = 0;
  issue_t sb_q[$];
  vec_t   vecs[7];

  always #5 clk = ~clk;

  episode_scheduler_if #(.EP_W(EPW), .STEP_W(STW), .EPS_W(EPSW)) bus ();

  episode_scheduler #(
    .NUM_EPISODES(NUM_EP),
    .MAX_STEPS   (MAX_ST),
    .EP_W        (EPW),
    .STEP_W      (STW),
    .EPS_W       (EPSW),
    .EPS_INIT    (16'd100),
    .EPS_DECAY   (16'd40),
    .EPS_MIN     (16'd30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.o_step_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_pulse(input string name);
    int n = 0;
    while (bus.o_step_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_pulse_seen"}, 32'(bus.o_step_valid), 1);
  endtask

  // Call while the issue pulse is visible; returns just after the strobe is taken.
  task automatic strobe(input logic term);
    tick();
    check("pulse_one_cycle", 32'(bus.o_step_valid), 0);
    bus.i_step_valid = 1'b1;
    bus.i_terminal   = term;
    tick();
    bus.i_step_valid = 1'b0;
    bus.i_terminal   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     base;
    int     wr_cycles;
    int     eps_m;
    issue_t exp;

    vecs[0] = '{term: 1'b0, ep: 0, step: 1, last_len: 4, eps: 100, sv: 1'b1, wreq: 1'b0};
    vecs[1] = '{term: 1'b1, ep: 1, step: 0, last_len: 2, eps: 60,  sv: 1'b1, wreq: 1'b0};
    vecs[2] = '{term: 1'b1, ep: 2, step: 0, last_len: 1, eps: 30,  sv: 1'b1, wreq: 1'b0};
    vecs[3] = '{term: 1'b0, ep: 2, step: 1, last_len: 1, eps: 30,  sv: 1'b1, wreq: 1'b0};
    vecs[4] = '{term: 1'b0, ep: 2, step: 2, last_len: 1, eps: 30,  sv: 1'b1, wreq: 1'b0};
    vecs[5] = '{term: 1'b0, ep: 2, step: 3, last_len: 1, eps: 30,  sv: 1'b1, wreq: 1'b0};
    vecs[6] = '{term: 1'b0, ep: 2, step: 0, last_len: 4, eps: 30,  sv: 1'b0, wreq: 1'b1};

    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_step_valid = 1'b0;
    bus.i_terminal = 1'b0;
    bus.i_write_done = 1'b0;

    // Reset is applied before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_episode",  32'(bus.o_episode), 0);
    check("rst_step",     32'(bus.o_step), 0);
    check("rst_last_len", 32'(bus.o_last_len), 0);
    check("rst_epsilon",  32'(bus.o_epsilon), E_INIT);
    check("rst_sv",       32'(bus.o_step_valid), 0);
    check("rst_wreq",     32'(bus.o_write_req), 0);
    check("rst_busy",     32'(bus.o_busy), 0);
    check("rst_done",     32'(bus.o_done), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    bus.i_step_valid = 1'b1;
    tick();
    bus.i_step_valid = 1'b0;
    check("idle_sv_ignored_busy", 32'(bus.o_busy), 0);
    check("idle_sv_ignored_step", 32'(bus.o_step), 0);

    // Full run, no terminals: scoreboard holds every expected issue.
    eps_m = E_INIT;
    for (int e = 0; e < NUM_EP; e++) begin
      for (int s = 0; s < MAX_ST; s++) sb_q.push_back('{ep: e, step: s, eps: eps_m});
      eps_m = eps_m - E_DEC;
      if (eps_m < E_MIN) eps_m = E_MIN;
    end

    base = pulse_cnt;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("start_busy", 32'(bus.o_busy), 1);
    for (int i = 0; i < NUM_EP * MAX_ST; i++) begin
      wait_pulse("runA");
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check("sb_episode", 32'(bus.o_episode), exp.ep);
        check("sb_step",    32'(bus.o_step), exp.step);
        check("sb_epsilon", 32'(bus.o_epsilon), exp.eps);
      end else begin
        check("sb_unexpected_issue", 32'(sb_q.size()), 1);
      end
      strobe(1'b0);
      if (i == NUM_EP * MAX_ST - 2) check("runA_no_early_wreq", 32'(bus.o_write_req), 0);
    end
    check("runA_sb_empty",    32'(sb_q.size()), 0);
    check("runA_pulse_count", 32'(pulse_cnt - base), 12);
    check("runA_wreq",        32'(bus.o_write_req), 1);
    check("runA_last_len",    32'(bus.o_last_len), 4);
    check("runA_epsilon",     32'(bus.o_epsilon), eps_m);
    check("runA_episode",     32'(bus.o_episode), NUM_EP - 1);
    check("runA_step",        32'(bus.o_step), 0);

    // Dump acknowledgement arrives in the tenth write cycle.
    wr_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.o_write_req === 1'b1) wr_cycles++;
      if (k == 5) check("done_early", 32'(bus.o_done), 0);
      if (k == 9) bus.i_write_done = 1'b1;
      tick();
    end
    bus.i_write_done = 1'b0;
    check("write_req_cycles",  32'(wr_cycles), 10);
    check("done_after_ack",    32'(bus.o_done), 1);
    check("done_wreq_low",     32'(bus.o_write_req), 0);
    check("done_busy_low",     32'(bus.o_busy), 0);

    bus.i_step_valid = 1'b1;
    tick();
    bus.i_step_valid = 1'b0;
    tick();
    check("done_hold_done",    32'(bus.o_done), 1);
    check("done_hold_episode", 32'(bus.o_episode), NUM_EP - 1);
    check("done_hold_step",    32'(bus.o_step), 0);

    // Restart from DONE; table covers terminals and the step cap.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("restart_episode",  32'(bus.o_episode), 0);
    check("restart_step",     32'(bus.o_step), 0);
    check("restart_epsilon",  32'(bus.o_epsilon), E_INIT);
    check("restart_done",     32'(bus.o_done), 0);
    check("restart_last_len", 32'(bus.o_last_len), 4);
    for (int i = 0; i < 7; i++) begin
      wait_pulse("runB");
      strobe(vecs[i].term);
      check("vec_episode",  32'(bus.o_episode), vecs[i].ep);
      check("vec_step",     32'(bus.o_step), vecs[i].step);
      check("vec_last_len", 32'(bus.o_last_len), vecs[i].last_len);
      check("vec_epsilon",  32'(bus.o_epsilon), vecs[i].eps);
      check("vec_sv",       32'(bus.o_step_valid), 32'(vecs[i].sv));
      check("vec_wreq",     32'(bus.o_write_req), 32'(vecs[i].wreq));
    end

    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("write_start_ignored_wreq", 32'(bus.o_write_req), 1);
    check("write_start_ignored_ep",   32'(bus.o_episode), NUM_EP - 1);

    // Asynchronous reset in the middle of WRITE.
    #3 rst = 1'b1;
    #1;
    check("async_rst_wreq",    32'(bus.o_write_req), 0);
    check("async_rst_busy",    32'(bus.o_busy), 0);
    check("async_rst_episode", 32'(bus.o_episode), 0);
    check("async_rst_epsilon", 32'(bus.o_epsilon), E_INIT);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.i_write_done = 1'b1;
    tick();
    bus.i_write_done = 1'b0;
    tick();
    check("post_rst_no_done", 32'(bus.o_done), 0);
    check("post_rst_no_wreq", 32'(bus.o_write_req), 0);

    // Abort in WAIT at episode 1 / step 2, colliding with a start.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_pulse("runC");
    strobe(1'b1);
    wait_pulse("runC");
    strobe(1'b0);
    wait_pulse("runC");
    strobe(1'b0);
    tick();
    check("pre_abort_busy", 32'(bus.o_busy), 1);
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    check("abort_busy",    32'(bus.o_busy), 0);
    check("abort_sv",      32'(bus.o_step_valid), 0);
    check("abort_episode", 32'(bus.o_episode), 1);
    check("abort_step",    32'(bus.o_step), 2);
    tick();
    check("abort_stays_idle", 32'(bus.o_busy), 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("restart2_episode", 32'(bus.o_episode), 0);
    check("restart2_step",    32'(bus.o_step), 0);
    check("restart2_sv",      32'(bus.o_step_valid), 1);
    check("restart2_busy",    32'(bus.o_busy), 1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("abort_issue_busy", 32'(bus.o_busy), 0);
    check("abort_issue_sv",   32'(bus.o_step_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
